// File: rtl/rv_pkg.sv
// Shared RV32I encoder definitions: instruction classes, opcodes and immediate limits.
package rv_pkg;

    typedef enum logic [3:0] {
        CLS_ALUREG = 4'd0,
        CLS_ALUIMM = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_SYSTEM = 4'd9
    } instr_class_e;

    localparam logic [6:0] OPC_ALUREG = 7'b0110011;
    localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/rv_enc_fifo.sv
// Synchronous FIFO buffering encoded words between the encoder and its consumer.
module rv_enc_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the read port is gated to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I instruction encoder with output FIFO and pop counter.
// Define ENC_RANGE_CHECK_EN to flag descriptors whose fields do not fit the format.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_class,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [31:0] encode_word(
        input logic [3:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic [11:0] i_imm;
        w     = '0;
        i_imm = imm[11:0];
        case (cls)
            CLS_ALUREG: w = {f7, rs2, rs1, f3, rd, OPC_ALUREG};
            CLS_ALUIMM: begin
                // Shifts carry shamt in imm[4:0]; the upper seven bits select logical vs arithmetic.
                if (f3 == 3'b001)      i_imm = {7'b0000000, imm[4:0]};
                else if (f3 == 3'b101) i_imm = {f7, imm[4:0]};
                w = {i_imm, rs1, f3, rd, OPC_ALUIMM};
            end
            CLS_LOAD:   w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            CLS_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            CLS_SYSTEM: w = {imm[11:0], rs1, f3, rd, OPC_SYSTEM};
            CLS_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            CLS_LUI:    w = {imm[31:12], rd, OPC_LUI};
            CLS_AUIPC:  w = {imm[31:12], rd, OPC_AUIPC};
            CLS_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default:    w = '0;
        endcase
        return w;
    endfunction

`ifdef ENC_RANGE_CHECK_EN
    function automatic logic range_err(
        input logic [3:0]  cls,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic err;
        err = 1'b0;
        case (cls)
            CLS_ALUIMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    err = (imm[31:5] != '0) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
                end else begin
                    err = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
                end
            end
            CLS_LOAD, CLS_JALR, CLS_SYSTEM, CLS_STORE:
                err = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
            CLS_BRANCH: err = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            CLS_JAL:    err = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
            CLS_LUI, CLS_AUIPC: err = (imm[11:0] != '0);
            CLS_ALUREG: err = 1'b0;
            default:    err = 1'b1;
        endcase
        return err;
    endfunction

    localparam int DATA_W = 33;
`else
    localparam int DATA_W = 32;
`endif

    logic [31:0]           enc_word;
    logic [DATA_W-1:0]     push_data, pop_data;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  push, pop;
    logic [CNT_W-1:0]      enc_count_q, enc_count_d;

    always_comb begin
        enc_word = encode_word(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
`ifdef ENC_RANGE_CHECK_EN
        push_data = {range_err(in_class, in_funct3, in_funct7, in_imm), enc_word};
`else
        push_data = enc_word;
`endif
    end

    assign in_ready  = (fifo_count < FIFO_CNT_W'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = pop_data[31:0];
`ifdef ENC_RANGE_CHECK_EN
    assign out_err   = pop_data[32];
`else
    assign out_err   = 1'b0;
`endif

    rv_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count)
    );

    always_comb begin
        enc_count_d = enc_count_q;
        if (pop) begin
            enc_count_d = enc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_q <= '0;
        end else begin
            enc_count_q <= enc_count_d;
        end
    end

    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder (works with or without ENC_RANGE_CHECK_EN).
module tb_rv_instr_encoder;
    import rv_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 32;

`ifdef ENC_RANGE_CHECK_EN
    localparam logic [31:0] CHK = 32'd1;
`else
    localparam logic [31:0] CHK = 32'd0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_class;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    int total = 0;
    int bad   = 0;

    rv_instr_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_desc(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_enc_count", enc_count, 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single ALUIMM, one-cycle latency, then pop.
        set_desc(CLS_ALUIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_word", out_instr, 32'h0050_0093);
        check("addi_err", {31'd0, out_err}, 32'd0);
        check("addi_cnt_before_pop", enc_count, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("addi_cnt_after_pop", enc_count, 32'd1);
        check("addi_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back pushes fill the FIFO; order preserved, no pass-through when full.
        set_desc(CLS_ALUREG, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        check("add_word", out_instr, 32'h0020_81B3);
        check("ready_after_one", {31'd0, in_ready}, 32'd1);
        set_desc(CLS_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        tick();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_head_word", out_instr, 32'h0020_81B3);
        set_desc(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8);
        tick();
        check("held_word", out_instr, 32'h0020_81B3);
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        check("held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("pop_full_word", out_instr, 32'h0020_A423);
        check("pop_full_in_ready", {31'd0, in_ready}, 32'd1);
        check("pop_full_cnt", enc_count, 32'd2);
        tick();
        check("beq_word", out_instr, 32'h0020_8463);
        check("beq_cnt", enc_count, 32'd3);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_cnt", enc_count, 32'd4);

        // Streaming J and U formats with consumer always ready.
        set_desc(CLS_JAL, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
        in_valid = 1'b1;
        tick();
        check("jal_word", out_instr, 32'h0080_006F);
        set_desc(CLS_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
        tick();
        check("lui_word", out_instr, 32'h1234_52B7);
        check("lui_cnt", enc_count, 32'd5);

        // Out-of-range / odd / shift / forced-funct3 / unknown-class vectors.
        set_desc(CLS_ALUIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096);
        tick();
        check("big_imm_word", out_instr, 32'h0000_0093);
        check("big_imm_err", {31'd0, out_err}, CHK);
        set_desc(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd7);
        tick();
        check("odd_br_word", out_instr, 32'h0020_8363);
        check("odd_br_err", {31'd0, out_err}, CHK);
        set_desc(CLS_ALUIMM, 5'd2, 5'd3, 5'd0, 3'b101, 7'h20, 32'd3);
        tick();
        check("srai_word", out_instr, 32'h4031_D113);
        check("srai_err", {31'd0, out_err}, 32'd0);
        set_desc(CLS_JALR, 5'd1, 5'd2, 5'd0, 3'b111, 7'd0, 32'hFFFF_FFFC);
        tick();
        check("jalr_word", out_instr, 32'hFFC1_00E7);
        check("jalr_err", {31'd0, out_err}, 32'd0);
        set_desc(4'hF, 5'd7, 5'd7, 5'd7, 3'b111, 7'h7F, 32'hFFFF_FFFF);
        tick();
        check("unknown_word", out_instr, 32'h0000_0000);
        check("unknown_err", {31'd0, out_err}, CHK);
        check("unknown_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("stream_cnt", enc_count, 32'd11);
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two words buffered.
        out_ready = 1'b0;
        set_desc(CLS_ALUIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        set_desc(CLS_ALUREG, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_cnt", enc_count, 32'd0);
        check("async_rst_word", out_instr, 32'd0);
        tick();
        rst_n = 1'b1;
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);
        set_desc(CLS_ALUIMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_word", out_instr, 32'h0050_0093);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("post_rst_cnt", enc_count, 32'd1);
        check("post_rst_drained", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
